// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, forwarding select codes and control-word bit positions for the pipeline.
package pipe_pkg;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 7;
    localparam int FUNCT_W = 10;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_RSVD  = 2'b11;

    localparam int CTRL_REGWR    = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_ALUSRC   = 0;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
        logic [RADDR_W-1:0] rd_addr;
        logic [CTRL_W-1:0]  ctrl;
        logic [FUNCT_W-1:0] funct;
    } idex_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the EX operand source for one register address; the younger EX/MEM result wins.
module fwd_select
    import pipe_pkg::*;
(
    input  logic               valid_i,
    input  logic [RADDR_W-1:0] src_i,
    input  logic               exmem_regwr_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               memwb_regwr_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    output logic [1:0]         sel_o
);
    logic exmem_hit, memwb_hit;

    // x0 is hardwired zero, so a write to it must never be forwarded
    always_comb begin
        exmem_hit = valid_i && exmem_regwr_i && exmem_rd_i != '0 && exmem_rd_i == src_i;
        memwb_hit = valid_i && memwb_regwr_i && memwb_rd_i != '0 && memwb_rd_i == src_i;
        sel_o     = exmem_hit ? FWD_EXMEM : memwb_hit ? FWD_MEMWB : FWD_IDEX;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush and EX operand forwarding selects.
// Define ID_EX_FORWARD_EN to generate the selects; otherwise they are tied to 00.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic [CTRL_W-1:0]  ctrl_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               exmem_regwr_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               memwb_regwr_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    output logic [XLEN-1:0]    rs1_data_o,
    output logic [XLEN-1:0]    rs2_data_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [RADDR_W-1:0] rs1_addr_o,
    output logic [RADDR_W-1:0] rs2_addr_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic               valid_o,
    output logic [1:0]         fwd_a_sel_o,
    output logic [1:0]         fwd_b_sel_o
);
    idex_t stage_d, stage_q;

    // flush beats stall so a squashed instruction can't linger in a held stage
    always_comb
        stage_d = flush_i ? '0 :
                  stall_i ? stage_q :
                  '{valid: 1'b1, rs1_data: rs1_data_i, rs2_data: rs2_data_i, imm: imm_i,
                    rs1_addr: rs1_addr_i, rs2_addr: rs2_addr_i, rd_addr: rd_addr_i,
                    ctrl: ctrl_i, funct: funct_i};

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) stage_q <= '0;
        else       stage_q <= stage_d;

    assign rs1_data_o = stage_q.rs1_data;
    assign rs2_data_o = stage_q.rs2_data;
    assign imm_o      = stage_q.imm;
    assign rs1_addr_o = stage_q.rs1_addr;
    assign rs2_addr_o = stage_q.rs2_addr;
    assign rd_addr_o  = stage_q.rd_addr;
    assign ctrl_o     = stage_q.ctrl;
    assign funct_o    = stage_q.funct;
    assign valid_o    = stage_q.valid;

`ifdef ID_EX_FORWARD_EN
    fwd_select u_fwd_a (
        .valid_i       (stage_q.valid),
        .src_i         (stage_q.rs1_addr),
        .exmem_regwr_i (exmem_regwr_i),
        .exmem_rd_i    (exmem_rd_i),
        .memwb_regwr_i (memwb_regwr_i),
        .memwb_rd_i    (memwb_rd_i),
        .sel_o         (fwd_a_sel_o)
    );

    fwd_select u_fwd_b (
        .valid_i       (stage_q.valid),
        .src_i         (stage_q.rs2_addr),
        .exmem_regwr_i (exmem_regwr_i),
        .exmem_rd_i    (exmem_rd_i),
        .memwb_regwr_i (memwb_regwr_i),
        .memwb_rd_i    (memwb_rd_i),
        .sel_o         (fwd_b_sel_o)
    );
`else
    logic unused_fwd;

    assign unused_fwd  = ^{exmem_regwr_i, exmem_rd_i, memwb_regwr_i, memwb_rd_i};
    assign fwd_a_sel_o = FWD_IDEX;
    assign fwd_b_sel_o = FWD_IDEX;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
    logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
    logic [6:0]  ctrl_i = '0;
    logic [9:0]  funct_i = '0;
    logic        exmem_regwr_i = 1'b0, memwb_regwr_i = 1'b0;
    logic [4:0]  exmem_rd_i = '0, memwb_rd_i = '0;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [6:0]  ctrl_o;
    logic [9:0]  funct_o;
    logic        valid_o;
    logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .ctrl_i(ctrl_i), .funct_i(funct_i),
        .exmem_regwr_i(exmem_regwr_i), .exmem_rd_i(exmem_rd_i),
        .memwb_regwr_i(memwb_regwr_i), .memwb_rd_i(memwb_rd_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .ctrl_o(ctrl_o), .funct_o(funct_o), .valid_o(valid_o),
        .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // reference model of what EX should currently hold
    logic        m_valid;
    logic [31:0] m_rs1, m_rs2, m_imm;
    logic [4:0]  m_a1, m_a2, m_rd;
    logic [6:0]  m_ctrl;
    logic [9:0]  m_funct;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_sel(input logic [4:0] a);
        if (!FWD_ON || !m_valid || a == 5'd0) return 2'b00;
        if (exmem_regwr_i && exmem_rd_i == a) return 2'b10;
        if (memwb_regwr_i && memwb_rd_i == a) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        {m_valid, m_rs1, m_rs2, m_imm, m_a1, m_a2, m_rd, m_ctrl, m_funct} = '0;
    endtask

    task automatic check_sel(input string tag);
        check({tag, ".sel"}, 128'({fwd_a_sel_o, fwd_b_sel_o}), 128'({ref_sel(m_a1), ref_sel(m_a2)}));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, 128'({rs1_data_o, rs2_data_o, imm_o}), 128'({m_rs1, m_rs2, m_imm}));
        check({tag, ".fields"}, 128'({rs1_addr_o, rs2_addr_o, rd_addr_o, ctrl_o, funct_o}),
              128'({m_a1, m_a2, m_rd, m_ctrl, m_funct}));
        check({tag, ".valid"}, 128'(valid_o), 128'(m_valid));
        check_sel(tag);
    endtask

    // one clock: the model applies the pipeline-register rules to the inputs seen at the edge
    task automatic step(input string tag);
        @(posedge clk_i);
        if (flush_i) model_clear();
        else if (!stall_i) begin
            m_valid = 1'b1;
            m_rs1 = rs1_data_i; m_rs2 = rs2_data_i; m_imm = imm_i;
            m_a1 = rs1_addr_i; m_a2 = rs2_addr_i; m_rd = rd_addr_i;
            m_ctrl = ctrl_i; m_funct = funct_i;
        end
        @(negedge clk_i);
        check_all(tag);
    endtask

    // asynchronous reset raised between edges must clear outputs without waiting for a clock
    task automatic async_reset(input string tag);
        #2 rst_i = 1'b1;
        #1 model_clear();
        check_all({tag, ".async"});
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check_all({tag, ".held"});
    endtask

    task automatic randomize_id();
        rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
        rs1_addr_i = 5'($urandom_range(0, 3)); rs2_addr_i = 5'($urandom_range(0, 3));
        rd_addr_i = 5'($urandom); ctrl_i = 7'($urandom); funct_i = 10'($urandom);
    endtask

    task automatic randomize_fwd();
        exmem_regwr_i = 1'($urandom); memwb_regwr_i = 1'($urandom);
        exmem_rd_i = 5'($urandom_range(0, 3)); memwb_rd_i = 5'($urandom_range(0, 3));
    endtask

    initial begin
        model_clear();
        @(negedge clk_i);
        async_reset("reset");

        rs1_data_i = 32'h1234;
        step("load");
        check("load.rs1", 128'(rs1_data_o), 128'(32'h1234));
        check("load.valid", 128'(valid_o), 128'(1));

        ctrl_i = 7'h55;
        step("ctrl55");
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            step("stall");
            check("stall.ctrl", 128'(ctrl_o), 128'(7'h55));
        end
        flush_i = 1'b1;
        step("stallflush");
        check("stallflush.ctrl", 128'(ctrl_o), 128'(0));
        check("stallflush.valid", 128'(valid_o), 128'(0));
        stall_i = 1'b0; flush_i = 1'b0;

        rs1_addr_i = 5'd5; rs2_addr_i = 5'd6;
        step("addr5");
        exmem_regwr_i = 1'b1; exmem_rd_i = 5'd5;
        #1 check("exmem.a", 128'(fwd_a_sel_o), 128'(FWD_ON ? 2'b10 : 2'b00));
        check("exmem.b", 128'(fwd_b_sel_o), 128'(2'b00));

        rs2_addr_i = 5'd7;
        step("addr7");
        exmem_rd_i = 5'd7; memwb_regwr_i = 1'b1; memwb_rd_i = 5'd7;
        #1 check("dual.b", 128'(fwd_b_sel_o), 128'(FWD_ON ? 2'b10 : 2'b00));
        exmem_regwr_i = 1'b0;
        #1 check("memwb.b", 128'(fwd_b_sel_o), 128'(FWD_ON ? 2'b01 : 2'b00));

        rs1_addr_i = 5'd0; exmem_regwr_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
        step("x0");
        check("x0.a", 128'(fwd_a_sel_o), 128'(2'b00));

        rs1_addr_i = 5'd9; exmem_rd_i = 5'd9;
        step("addr9");
        check("addr9.a", 128'(fwd_a_sel_o), 128'(FWD_ON ? 2'b10 : 2'b00));
        flush_i = 1'b1;
        step("bubble");
        check("bubble.a", 128'(fwd_a_sel_o), 128'(2'b00));
        flush_i = 1'b0;

        randomize_id();
        step("prestall");
        stall_i = 1'b1; flush_i = 1'b1;
        async_reset("reset_midstall");
        stall_i = 1'b0; flush_i = 1'b0;

        for (int i = 0; i < 600; i++) begin
            randomize_id();
            randomize_fwd();
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            #1 check_sel("rnd.pre");
            if ($urandom_range(0, 59) == 0) async_reset("rnd.reset");
            else step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
